// File: rtl/window_feeder_if.sv
// Bundle of control, character, window and mesh-override signals around window_feeder.
// master is the feeder side; slave is the producer/mesh side.
interface window_feeder_if #(
   parameter int CHARACTER_WIDTH = 8,
   parameter int PC_WIDTH        = 8,
   parameter int CC_ID_BITS      = 1
);
   localparam int W = 2 ** CC_ID_BITS;

   logic                          start;
   logic [PC_WIDTH-1:0]           start_pc;
   logic                          char_valid;
   logic                          char_ready;
   logic [CHARACTER_WIDTH-1:0]    char_data;
   logic                          char_last;
   logic [W*CHARACTER_WIDTH-1:0]  cur_window;
   logic [W-1:0]                  cur_window_enable;
   logic [W-1:0]                  cur_window_end_of_s;
   logic                          new_char;
   logic [W-1:0]                  elaborating_chars;
   logic                          any_bb_accept;
   logic                          any_bb_running;
   logic                          override_valid;
   logic                          override_ready;
   logic [PC_WIDTH+CC_ID_BITS-1:0] override_data;
   logic                          busy;
   logic                          done;
   logic                          accepted;

   modport master (
      input  start, start_pc, char_valid, char_data, char_last,
             elaborating_chars, any_bb_accept, any_bb_running, override_ready,
      output char_ready, cur_window, cur_window_enable, cur_window_end_of_s,
             new_char, override_valid, override_data, busy, done, accepted
   );

   modport slave (
      output start, start_pc, char_valid, char_data, char_last,
             elaborating_chars, any_bb_accept, any_bb_running, override_ready,
      input  char_ready, cur_window, cur_window_enable, cur_window_end_of_s,
             new_char, override_valid, override_data, busy, done, accepted
   );
endinterface

// File: rtl/window_feeder.sv
// Keeps a circular window of character slots loaded ahead of the coprocessor mesh,
// injects one start-PC token per character and retires slots once the mesh is done with them.
module window_feeder #(
   parameter int CHARACTER_WIDTH = 8,
   parameter int PC_WIDTH        = 8,
   parameter int CC_ID_BITS      = 1,
   parameter int SETTLE_CYCLES   = 2
) (
   input logic clk,
   input logic rst,
   window_feeder_if.master bus
);
   localparam int W = 2 ** CC_ID_BITS;
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t state_q, state_d;

   logic [W-1:0][CHARACTER_WIDTH-1:0] slot_q, slot_d;
   logic [W-1:0]          enable_q, enable_d;
   logic [W-1:0]          endOfS_q, endOfS_d;
   logic [W-1:0]          injected_q, injected_d;
   logic [CC_ID_BITS-1:0] head_q, head_d;
   logic [CC_ID_BITS-1:0] tail_q, tail_d;
   logic [CC_ID_BITS-1:0] inj_q, inj_d;
   logic                  lastSeen_q, lastSeen_d;
   logic                  accepted_q, accepted_d;
   logic                  newChar_q, newChar_d;
   logic                  done_q, done_d;
   logic [3:0]            settle_q, settle_d;
   logic [PC_WIDTH-1:0]   startPc_q, startPc_d;

   logic startFire;
   logic charReady;
   logic overrideValid;
   logic fillFire;
   logic injFire;
   logic retireFire;
   logic drainExit;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: the string ends when the slot carrying the terminator retires,
   // then waits for the mesh to quiesce before reporting completion.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (retireFire && endOfS_q[head_q]) state_d = DRAIN;
         DRAIN:   if (!bus.any_bb_running) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake qualifiers; ready/valid depend on registered state only.
   always_comb begin
      startFire     = (state_q == IDLE) && bus.start;
      charReady     = (state_q == RUN) && !enable_q[tail_q] && !lastSeen_q;
      overrideValid = (state_q == RUN) && enable_q[inj_q] && !injected_q[inj_q];
      fillFire      = charReady && bus.char_valid;
      injFire       = overrideValid && bus.override_ready;
      retireFire    = (state_q == RUN) && enable_q[head_q] && injected_q[head_q]
                      && !bus.elaborating_chars[head_q] && (settle_q == 4'd0);
      drainExit     = (state_q == DRAIN) && !bus.any_bb_running;
   end

   // Window bookkeeping. Fill always targets an empty slot and retire a full one,
   // so both can update the same vectors in one cycle without colliding.
   always_comb begin
      slot_d     = slot_q;
      enable_d   = enable_q;
      endOfS_d   = endOfS_q;
      injected_d = injected_q;
      head_d     = head_q;
      tail_d     = tail_q;
      inj_d      = inj_q;
      lastSeen_d = lastSeen_q;
      accepted_d = accepted_q;
      startPc_d  = startPc_q;
      settle_d   = (settle_q != 4'd0) ? settle_q - 4'd1 : 4'd0;
      newChar_d  = 1'b0;
      done_d     = drainExit;

      if (startFire) begin
         slot_d     = '0;
         enable_d   = '0;
         endOfS_d   = '0;
         injected_d = '0;
         head_d     = '0;
         tail_d     = '0;
         inj_d      = '0;
         lastSeen_d = 1'b0;
         accepted_d = 1'b0;
         settle_d   = 4'd0;
         startPc_d  = bus.start_pc;
      end

      if (fillFire) begin
         slot_d[tail_q]     = bus.char_data;
         enable_d[tail_q]   = 1'b1;
         endOfS_d[tail_q]   = bus.char_last;
         injected_d[tail_q] = 1'b0;
         tail_d             = tail_q + 1'b1;
         if (bus.char_last) lastSeen_d = 1'b1;
      end

      if (injFire) begin
         injected_d[inj_q] = 1'b1;
         inj_d             = inj_q + 1'b1;
         settle_d          = SETTLE_LOAD;
      end

      if (retireFire) begin
         enable_d[head_q] = 1'b0;
         endOfS_d[head_q] = 1'b0;
         head_d           = head_q + 1'b1;
         settle_d         = SETTLE_LOAD;
         newChar_d        = 1'b1;
      end

      if ((state_q != IDLE) && bus.any_bb_accept) accepted_d = 1'b1;
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_q     <= '0;
         enable_q   <= '0;
         endOfS_q   <= '0;
         injected_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         inj_q      <= '0;
         lastSeen_q <= 1'b0;
         accepted_q <= 1'b0;
         newChar_q  <= 1'b0;
         done_q     <= 1'b0;
         settle_q   <= 4'd0;
         startPc_q  <= '0;
      end else begin
         slot_q     <= slot_d;
         enable_q   <= enable_d;
         endOfS_q   <= endOfS_d;
         injected_q <= injected_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         inj_q      <= inj_d;
         lastSeen_q <= lastSeen_d;
         accepted_q <= accepted_d;
         newChar_q  <= newChar_d;
         done_q     <= done_d;
         settle_q   <= settle_d;
         startPc_q  <= startPc_d;
      end
   end

   assign bus.char_ready          = charReady;
   assign bus.override_valid      = overrideValid;
   assign bus.override_data       = {inj_q, startPc_q};
   assign bus.cur_window          = slot_q;
   assign bus.cur_window_enable   = enable_q;
   assign bus.cur_window_end_of_s = endOfS_q;
   assign bus.new_char            = newChar_q;
   assign bus.busy                = (state_q != IDLE);
   assign bus.done                = done_q;
   assign bus.accepted            = accepted_q;
endmodule

// File: tb/tb_window_feeder.sv
// Self-checking bench for window_feeder: directed scenarios plus randomized strings,
// judged by an event-level model of tokens, retires and completion.
module tb_window_feeder;
   localparam int CW     = 8;
   localparam int PCW    = 8;
   localparam int CCB    = 1;
   localparam int W      = 2;
   localparam int SETTLE = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   window_feeder_if #(.CHARACTER_WIDTH(CW), .PC_WIDTH(PCW), .CC_ID_BITS(CCB)) bus ();

   window_feeder #(
      .CHARACTER_WIDTH(CW), .PC_WIDTH(PCW), .CC_ID_BITS(CCB), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int compareCount = 0;
   int failCount    = 0;

   // Mesh-side inputs come either from directed values or from the random driver.
   bit           randMode = 1'b0;
   logic         readyDir = 1'b1;
   logic [W-1:0] elabDir  = '0;
   logic         readyRnd = 1'b1;
   logic [W-1:0] elabRnd  = '0;
   assign bus.override_ready    = randMode ? readyRnd : readyDir;
   assign bus.elaborating_chars = randMode ? elabRnd  : elabDir;

   always @(posedge clk) begin
      #1;
      readyRnd = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < W; i++) elabRnd[i] = ($urandom_range(0, 9) < 3);
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference model: the k-th character of a string lives in slot k mod W, its token is
   // {k mod W, start_pc}, and it may retire only SETTLE cycles after every earlier
   // token/retire handshake and only while the mesh is not elaborating it.
   int             expLen = 0;
   logic [PCW-1:0] expPc  = '0;
   int             cyc = 0;
   int             retireCount = 0;
   int             tokCount = 0;
   int             doneCount = 0;
   logic [CW-1:0]  charHist[$];
   int             hsCycles[$];
   int             tokCycle[64];
   int             mSlot, mR, mLastHs;
   logic [W*CW-1:0] prevWindow;
   logic [W-1:0]   prevEnable, prevEos, prevElab;
   logic           prevRunning;

   always @(negedge clk) begin
      cyc++;
      if (bus.start && !bus.busy && rst) begin
         retireCount = 0;
         tokCount    = 0;
         doneCount   = 0;
         charHist.delete();
         hsCycles.delete();
      end
      if (bus.new_char) begin
         mSlot   = retireCount % W;
         mR      = cyc - 1;
         mLastHs = -1000;
         foreach (hsCycles[i]) if (hsCycles[i] < mR && hsCycles[i] > mLastHs) mLastHs = hsCycles[i];
         checkOutput("retire_settle", 64'((mR - mLastHs) >= SETTLE), 1);
         checkOutput("retire_after_token",
                     64'((retireCount < tokCount) && (mR - tokCycle[retireCount % 64] >= SETTLE)), 1);
         checkOutput("retire_not_elaborating", prevElab[mSlot], 0);
         checkOutput("retire_was_enabled", prevEnable[mSlot], 1);
         checkOutput("retire_cleared", bus.cur_window_enable[mSlot], 0);
         if (retireCount < charHist.size())
            checkOutput("retire_char", prevWindow[mSlot*CW +: CW], charHist[retireCount]);
         checkOutput("retire_eos", prevEos[mSlot], 64'(retireCount == expLen - 1));
         retireCount++;
         hsCycles.push_back(mR);
      end
      if (bus.char_valid && bus.char_ready) charHist.push_back(bus.char_data);
      if (bus.override_valid && bus.override_ready) begin
         checkOutput("token", bus.override_data, {CCB'(tokCount % W), expPc});
         tokCycle[tokCount % 64] = cyc;
         tokCount++;
         hsCycles.push_back(cyc);
      end
      if (bus.done) begin
         checkOutput("done_busy_low", bus.busy, 0);
         checkOutput("done_after_running", prevRunning, 0);
         checkOutput("done_all_retired", retireCount, expLen);
         doneCount++;
      end
      prevWindow  = bus.cur_window;
      prevEnable  = bus.cur_window_enable;
      prevEos     = bus.cur_window_end_of_s;
      prevElab    = bus.elaborating_chars;
      prevRunning = bus.any_bb_running;
   end

   logic [CW-1:0] chars[$];

   task automatic applyStimulus(input logic [PCW-1:0] pc, input int len);
      @(posedge clk); #1;
      expLen = len;
      expPc  = pc;
      bus.start = 1'b1;
      bus.start_pc = pc;
      bus.any_bb_running = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.start_pc = PCW'($urandom);
      @(negedge clk);
      checkOutput("start_busy", bus.busy, 1);
      checkOutput("start_accepted_cleared", bus.accepted, 0);
      @(posedge clk); #1;
   endtask

   task automatic sendChar(input logic [CW-1:0] c, input logic last);
      int   budget;
      logic hs;
      budget = 0;
      hs = 1'b0;
      bus.char_valid = 1'b1;
      bus.char_data  = c;
      bus.char_last  = last;
      while (!hs && budget < 500) begin
         @(negedge clk);
         hs = bus.char_ready;
         budget++;
      end
      @(posedge clk); #1;
      bus.char_valid = 1'b0;
      bus.char_last  = 1'b0;
      checkOutput("char_accepted", hs, 1);
   endtask

   task automatic pulseAccept();
      bus.any_bb_accept = 1'b1;
      @(posedge clk); #1;
      bus.any_bb_accept = 1'b0;
   endtask

   task automatic finishString(input logic expAccepted);
      int budget;
      budget = 0;
      while (retireCount < expLen && budget < 3000) begin
         @(negedge clk);
         budget++;
      end
      checkOutput("all_retired", retireCount, expLen);
      repeat (4) begin
         @(negedge clk);
         checkOutput("no_done_while_running", bus.done, 0);
      end
      @(posedge clk); #1;
      bus.any_bb_running = 1'b0;
      budget = 0;
      while (doneCount == 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      checkOutput("done_seen", doneCount, 1);
      repeat (3) @(negedge clk);
      checkOutput("done_once", doneCount, 1);
      checkOutput("tokens_issued", tokCount, expLen);
      checkOutput("idle_busy", bus.busy, 0);
      checkOutput("accepted_sticky", bus.accepted, expAccepted);
      for (int k = 0; k < chars.size(); k++)
         checkOutput("char_order", (k < charHist.size()) ? charHist[k] : 8'hxx, chars[k]);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_char_ready"}, bus.char_ready, 0);
      checkOutput({tag, "_override_valid"}, bus.override_valid, 0);
      checkOutput({tag, "_override_data"}, bus.override_data, 0);
      checkOutput({tag, "_window"}, bus.cur_window, 0);
      checkOutput({tag, "_enable"}, bus.cur_window_enable, 0);
      checkOutput({tag, "_eos"}, bus.cur_window_end_of_s, 0);
      checkOutput({tag, "_new_char"}, bus.new_char, 0);
      checkOutput({tag, "_busy"}, bus.busy, 0);
      checkOutput({tag, "_done"}, bus.done, 0);
      checkOutput({tag, "_accepted"}, bus.accepted, 0);
   endtask

   initial begin
      logic [PCW-1:0] pc;
      int             len;
      logic           acc;

      bus.start = 1'b0;
      bus.start_pc = '0;
      bus.char_valid = 1'b0;
      bus.char_data = '0;
      bus.char_last = 1'b0;
      bus.any_bb_accept = 1'b0;
      bus.any_bb_running = 1'b0;

      repeat (2) @(negedge clk);
      checkAllZero("por");
      rst = 1'b1;

      // "ab" with the mesh always ready and idle.
      chars = '{8'h61, 8'h62};
      applyStimulus(8'h05, 2);
      sendChar(8'h61, 1'b0);
      sendChar(8'h62, 1'b1);
      finishString(1'b0);

      // Slot 0 pinned by the mesh for 10 cycles.
      chars = '{8'h78};
      applyStimulus(8'h3C, 1);
      elabDir = 2'b01;
      sendChar(8'h78, 1'b1);
      repeat (10) begin
         @(negedge clk);
         checkOutput("elab_hold_no_new_char", bus.new_char, 0);
      end
      checkOutput("elab_hold_enabled", bus.cur_window_enable[0], 1);
      @(posedge clk); #1;
      elabDir = '0;
      finishString(1'b0);

      // Token channel stalled with both slots loaded, then reset mid-string.
      chars = '{};
      applyStimulus(8'hA7, 2);
      readyDir = 1'b0;
      sendChar(8'h11, 1'b0);
      sendChar(8'h22, 1'b0);
      repeat (5) begin
         @(negedge clk);
         checkOutput("stall_override_data", bus.override_data, {1'b0, 8'hA7});
         checkOutput("stall_override_valid", bus.override_valid, 1);
         checkOutput("stall_no_retire", bus.new_char, 0);
      end
      checkOutput("full_char_ready", bus.char_ready, 0);
      checkOutput("full_enable", bus.cur_window_enable, 2'b11);
      checkOutput("full_window", bus.cur_window, 16'h2211);
      #2 rst = 1'b0;
      #1 checkAllZero("reset");
      @(negedge clk);
      rst = 1'b1;
      readyDir = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("post_reset_override_valid", bus.override_valid, 0);
         checkOutput("post_reset_busy", bus.busy, 0);
      end

      // Five characters through two slots, with an accept pulse mid-string.
      pc = PCW'($urandom);
      chars = '{};
      for (int k = 0; k < 5; k++) chars.push_back(CW'($urandom));
      applyStimulus(pc, 5);
      for (int k = 0; k < 5; k++) begin
         sendChar(chars[k], 1'(k == 4));
         if (k == 2) pulseAccept();
      end
      finishString(1'b1);

      // Randomized strings with a jittery token channel and mesh.
      for (int t = 0; t < 6; t++) begin
         pc  = PCW'($urandom);
         len = $urandom_range(1, 8);
         acc = 1'($urandom_range(0, 1));
         chars = '{};
         for (int k = 0; k < len; k++) chars.push_back(CW'($urandom));
         randMode = 1'b1;
         applyStimulus(pc, len);
         for (int k = 0; k < len; k++) begin
            sendChar(chars[k], 1'(k == len - 1));
            if (acc && k == len / 2) pulseAccept();
         end
         finishString(acc);
         randMode = 1'b0;
         readyDir = 1'b1;
         elabDir  = '0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end
endmodule
